// File: rtl/ml_dsa_pkg.sv
// ml_dsa_pkg
// Shared constants, types and reduction helpers for the ML-DSA NTT datapath.
// Arithmetic is over Z_q with q = 8380417 = 2^23 - 2^13 + 1.
// Contents:
//   DATA_W        coefficient width (23)
//   Q             modulus
//   coeff_t       canonical coefficient type
//   fold1/fold2   partial reductions using 2^23 == 2^13 - 1 (mod q)
//   reduce_final  brings a fold2 result into [0, q-1]
package ml_dsa_pkg;

    localparam int DATA_W  = 23;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int FOLD1_W = 37;
    localparam int FOLD2_W = 27;
    localparam logic [DATA_W-1:0] Q = 23'd8380417;

    typedef logic [DATA_W-1:0] coeff_t;

    // P = lo + hi*2^23 == lo + hi*2^13 - hi. The result is never negative
    // because hi*(2^13-1) >= 0, and stays below 2^23 + 2^36.
    function automatic logic [FOLD1_W-1:0] fold1(input logic [PROD_W-1:0] p);
        logic [FOLD1_W-1:0] lo;
        logic [FOLD1_W-1:0] hi_shl;
        logic [FOLD1_W-1:0] hi;
        lo     = {14'd0, p[22:0]};
        hi_shl = {1'b0, p[45:23], 13'd0};
        hi     = {14'd0, p[45:23]};
        return lo + hi_shl - hi;
    endfunction

    // Second application of the same identity. For a product of canonical
    // operands the high part here is at most about 2^13, so the result fits
    // in 27 bits (below roughly 9q).
    function automatic logic [FOLD2_W-1:0] fold2(input logic [FOLD1_W-1:0] r);
        logic [FOLD2_W-1:0] lo;
        logic [FOLD2_W-1:0] hi_shl;
        logic [FOLD2_W-1:0] hi;
        lo     = {4'd0, r[22:0]};
        hi_shl = {r[36:23], 13'd0};
        hi     = {13'd0, r[36:23]};
        return lo + hi_shl - hi;
    endfunction

    // Subtracting k*q with k = r[26:23] is the same as replacing k*2^23 with
    // k*(2^13-1). Since k*2^23 <= r, k never overshoots, and the remainder is
    // below 2^23 + 15*8191 < 2q, so one conditional subtraction finishes it.
    // The 23-bit subtraction wraps to the correct value whenever it is used.
    function automatic coeff_t reduce_final(input logic [FOLD2_W-1:0] r);
        logic [23:0] rem;
        coeff_t      rem_minus_q;
        rem         = {1'b0, r[22:0]} + ({20'd0, r[26:23]} * 24'd8191);
        rem_minus_q = rem[22:0] - Q;
        return (rem >= {1'b0, Q}) ? rem_minus_q : rem[22:0];
    endfunction

endpackage

// File: rtl/mod_mul.sv
// mod_mul
// Pipelined modular multiplier t = zeta * b mod q, exact (no Montgomery factor).
// Latency 3: operands sampled at edge k, t valid after edge k+2.
// Ports:
//   clk   in   clock, rising edge
//   b     in   23-bit canonical multiplicand
//   zeta  in   23-bit canonical twiddle
//   t     out  23-bit canonical product mod q
// The datapath carries no valid bits and needs no reset; qualification is
// done by the enclosing unit.
module mod_mul
    import ml_dsa_pkg::*;
(
    input  logic              clk,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] zeta,
    output logic [DATA_W-1:0] t
);

    logic [PROD_W-1:0]  prod_q;
    logic [FOLD1_W-1:0] fold1_q;
    coeff_t             t_q;

    // Stage 1 registers the full product, stage 2 the first fold, stage 3
    // the second fold together with the final correction.
    always_ff @(posedge clk) begin
        prod_q  <= {23'd0, zeta} * {23'd0, b};
        fold1_q <= fold1(prod_q);
        t_q     <= reduce_final(fold2(fold1_q));
    end

    assign t = t_q;

endmodule

// File: rtl/bt_unit.sv
// bt_unit
// Cooley-Tukey butterfly over Z_q:
//   t = zeta*B mod q, A_out = (A + t) mod q, B_out = (A - t) mod q.
// Fully pipelined, one operation per cycle, latency 4 cycles.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high; flushes in-flight ops, zeroes outputs
//   en     in   request; A_in/B_in/zeta sampled on every edge with en=1
//   A_in   in   23-bit canonical coefficient A
//   B_in   in   23-bit canonical coefficient B
//   zeta   in   23-bit canonical twiddle
//   A_out  out  (A + zeta*B) mod q, holds until the next result
//   B_out  out  (A - zeta*B) mod q, holds until the next result
//   valid  out  one-cycle pulse per accepted op, aligned with A_out/B_out
module bt_unit
    import ml_dsa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic [DATA_W-1:0] zeta,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic              valid
);

    logic [3:0]  vld_pipe;
    coeff_t      a_d0;
    coeff_t      a_d1;
    coeff_t      a_d2;
    coeff_t      t_val;
    logic [23:0] sum_raw;
    logic [23:0] diff_raw;
    coeff_t      sum_fix;
    coeff_t      diff_fix;

    mod_mul u_mod_mul (
        .clk  (clk),
        .b    (B_in),
        .zeta (zeta),
        .t    (t_val)
    );

    // Only the valid bits are flushed by reset; stale data left in the
    // datapath registers can never reach the outputs without a valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= 4'd0;
        end else begin
            vld_pipe <= {vld_pipe[2:0], en};
        end
    end

    // A travels three stages so it meets its own t, then the raw sum and
    // difference are registered before correction.
    always_ff @(posedge clk) begin
        a_d0     <= A_in;
        a_d1     <= a_d0;
        a_d2     <= a_d1;
        sum_raw  <= {1'b0, a_d2} + {1'b0, t_val};
        diff_raw <= {1'b0, a_d2} - {1'b0, t_val};
    end

    // sum_raw lies in [0, 2q-2] and diff_raw in (-q, q); the 23-bit
    // corrections wrap to the right value whenever they are selected.
    assign sum_fix  = sum_raw[22:0] - Q;
    assign diff_fix = diff_raw[22:0] + Q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            A_out <= '0;
            B_out <= '0;
        end else begin
            valid <= vld_pipe[3];
            if (vld_pipe[3]) begin
                A_out <= (sum_raw >= {1'b0, Q}) ? sum_fix : sum_raw[22:0];
                B_out <= diff_raw[23] ? diff_fix : diff_raw[22:0];
            end
        end
    end

endmodule

// File: tb/tb_bt_unit.sv
// tb_bt_unit
// Self-checking bench for bt_unit. A reference model predicts, per clock edge,
// whether a result is due and what it is, computed directly as
// (A +/- zeta*B) mod q from a queue of accepted requests.
module tb_bt_unit;

    localparam longint unsigned QM = 64'd8380417;

    logic        clk;
    logic        reset;
    logic        en;
    logic [22:0] a_in;
    logic [22:0] b_in;
    logic [22:0] zeta;
    logic [22:0] a_out;
    logic [22:0] b_out;
    logic        valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [22:0] ea;
        logic [22:0] eb;
    } op_t;

    op_t         pend[$];
    int          cyc = 0;
    logic        exp_valid;
    logic [22:0] exp_a;
    logic [22:0] exp_b;

    bt_unit dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .A_in  (a_in),
        .B_in  (b_in),
        .zeta  (zeta),
        .A_out (a_out),
        .B_out (b_out),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [22:0] gold_add(input logic [22:0] a, input logic [22:0] b,
                                             input logic [22:0] z);
        longint unsigned t;
        t = (64'(z) * 64'(b)) % QM;
        return 23'((64'(a) + t) % QM);
    endfunction

    function automatic logic [22:0] gold_sub(input logic [22:0] a, input logic [22:0] b,
                                             input logic [22:0] z);
        longint unsigned t;
        t = (64'(z) * 64'(b)) % QM;
        return 23'((64'(a) + QM - t) % QM);
    endfunction

    // Mostly uniform canonical values, with extra weight on 0 and q-1.
    function automatic logic [22:0] rand_coeff();
        int sel;
        sel = $urandom_range(9, 0);
        if (sel == 0) return 23'd0;
        if (sel == 1) return 23'd8380416;
        return 23'($urandom_range(8380416, 0));
    endfunction

    // Drive one cycle of inputs, take the edge, advance the model, and leave
    // the caller 1 time unit after the edge to sample outputs.
    task automatic step(input logic r, input logic e, input logic [22:0] a,
                        input logic [22:0] b, input logic [22:0] z);
        op_t o;
        reset = r;
        en    = e;
        a_in  = a;
        b_in  = b;
        zeta  = z;
        @(posedge clk);
        cyc++;
        if (r) begin
            pend.delete();
            exp_valid = 1'b0;
            exp_a     = 23'd0;
            exp_b     = 23'd0;
        end else begin
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                o         = pend.pop_front();
                exp_valid = 1'b1;
                exp_a     = o.ea;
                exp_b     = o.eb;
            end
            if (e) begin
                o.due = cyc + 4;
                o.ea  = gold_add(a, b, z);
                o.eb  = gold_sub(a, b, z);
                pend.push_back(o);
            end
        end
        #1;
    endtask

    // Reset with en held high: outputs zero, and the requests are ignored.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cyc %0d got %0d expected 0", cyc, valid);
            end
            checks++;
            if (a_out !== 23'd0) begin
                errors++;
                $display("[TB] FAIL reset_a_out cyc %0d got %0d expected 0", cyc, a_out);
            end
            checks++;
            if (b_out !== 23'd0) begin
                errors++;
                $display("[TB] FAIL reset_b_out cyc %0d got %0d expected 0", cyc, b_out);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_en_ignored cyc %0d got %0d expected 0", cyc, valid);
            end
        end
    endtask

    // Single isolated operations with hand-derived results.
    task automatic test_directed();
        logic [22:0] va[5];
        logic [22:0] vb[5];
        logic [22:0] vz[5];
        logic [22:0] ra[5];
        logic [22:0] rb[5];
        va = '{23'd1, 23'd0, 23'd5, 23'd8380416, 23'd8380416};
        vb = '{23'd3, 23'd1, 23'd1, 23'd8380416, 23'd0};
        vz = '{23'd3383, 23'd8380416, 23'd8380416, 23'd8380416, 23'd12345};
        ra = '{23'd10150, 23'd8380416, 23'd4, 23'd0, 23'd8380416};
        rb = '{23'd8370269, 23'd1, 23'd6, 23'd8380415, 23'd8380416};
        for (int v = 0; v < 5; v++) begin
            step(1'b0, 1'b1, va[v], vb[v], vz[v]);
            for (int c = 1; c <= 5; c++) begin
                step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
                checks++;
                if (valid !== (c == 4)) begin
                    errors++;
                    $display("[TB] FAIL directed%0d_valid_c%0d got %0d expected %0d",
                             v, c, valid, (c == 4));
                end
                if (c == 4) begin
                    checks++;
                    if (a_out !== ra[v]) begin
                        errors++;
                        $display("[TB] FAIL directed%0d_a_out got %0d expected %0d",
                                 v, a_out, ra[v]);
                    end
                    checks++;
                    if (b_out !== rb[v]) begin
                        errors++;
                        $display("[TB] FAIL directed%0d_b_out got %0d expected %0d",
                                 v, b_out, rb[v]);
                    end
                end
            end
        end
    endtask

    // 64 consecutive random requests: 64 consecutive valid cycles, in order.
    task automatic test_back_to_back();
        int n_valid = 0;
        int first_v = -1;
        int last_v  = -1;
        for (int i = 0; i < 72; i++) begin
            if (i < 64) step(1'b0, 1'b1, rand_coeff(), rand_coeff(), rand_coeff());
            else        step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL b2b_valid cyc %0d got %0d expected %0d", cyc, valid, exp_valid);
            end
            if (valid === 1'b1) begin
                n_valid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (exp_valid) begin
                checks++;
                if (a_out !== exp_a) begin
                    errors++;
                    $display("[TB] FAIL b2b_a_out cyc %0d got %0d expected %0d", cyc, a_out, exp_a);
                end
                checks++;
                if (b_out !== exp_b) begin
                    errors++;
                    $display("[TB] FAIL b2b_b_out cyc %0d got %0d expected %0d", cyc, b_out, exp_b);
                end
            end
        end
        checks++;
        if (n_valid != 64) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d expected 64", n_valid);
        end
        checks++;
        if (last_v - first_v + 1 != 64) begin
            errors++;
            $display("[TB] FAIL b2b_contiguous got span %0d expected 64", last_v - first_v + 1);
        end
    endtask

    // Random en pattern: gaps in requests must reappear as gaps in valid.
    task automatic test_gaps();
        logic e;
        for (int i = 0; i < 48; i++) begin
            e = (i < 40) ? 1'($urandom_range(1, 0)) : 1'b0;
            step(1'b0, e, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL gaps_valid cyc %0d got %0d expected %0d", cyc, valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (a_out !== exp_a || b_out !== exp_b) begin
                    errors++;
                    $display("[TB] FAIL gaps_data cyc %0d got %0d/%0d expected %0d/%0d",
                             cyc, a_out, b_out, exp_a, exp_b);
                end
            end
        end
    endtask

    // Three ops in flight are flushed by a one-cycle reset; a later op runs
    // normally. Then ten idle cycles must hold that result.
    task automatic test_reset_midflight_and_hold();
        logic [22:0] a;
        logic [22:0] b;
        logic [22:0] z;
        logic [22:0] hold_a;
        logic [22:0] hold_b;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, rand_coeff(), 23'($urandom_range(8380416, 1)), 23'($urandom_range(8380416, 1)));
        end
        step(1'b1, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
        checks++;
        if (valid !== 1'b0 || a_out !== 23'd0 || b_out !== 23'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear got v=%0d a=%0d b=%0d expected 0/0/0", valid, a_out, b_out);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_no_valid cyc %0d got %0d expected 0", cyc, valid);
            end
        end
        a = rand_coeff();
        b = 23'($urandom_range(8380416, 1));
        z = 23'($urandom_range(8380416, 1));
        hold_a = gold_add(a, b, z);
        hold_b = gold_sub(a, b, z);
        step(1'b0, 1'b1, a, b, z);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== (c == 4)) begin
                errors++;
                $display("[TB] FAIL post_reset_valid_c%0d got %0d expected %0d", c, valid, (c == 4));
            end
        end
        checks++;
        if (a_out !== hold_a || b_out !== hold_b) begin
            errors++;
            $display("[TB] FAIL post_reset_data got %0d/%0d expected %0d/%0d", a_out, b_out, hold_a, hold_b);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, rand_coeff(), rand_coeff(), rand_coeff());
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_valid cyc %0d got %0d expected 0", cyc, valid);
            end
            checks++;
            if (a_out !== hold_a || b_out !== hold_b) begin
                errors++;
                $display("[TB] FAIL hold_data cyc %0d got %0d/%0d expected %0d/%0d",
                         cyc, a_out, b_out, hold_a, hold_b);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        a_in      = 23'd0;
        b_in      = 23'd0;
        zeta      = 23'd0;
        exp_valid = 1'b0;
        exp_a     = 23'd0;
        exp_b     = 23'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_gaps();
        test_reset_midflight_and_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_unit.md
# bt_unit

Pipelined Cooley–Tukey butterfly for the ML-DSA NTT datapath over Z_q, q = 8380417 = 2^23 − 2^13 + 1. Each accepted operation computes t = zeta·B mod q, then A_out = (A + t) mod q and B_out = (A − t) mod q. It sits under the NTT controller, which supplies coefficient pairs and twiddles from memory at up to one pair per cycle.

## Interface
Parameters:
- none; width 23 and modulus q come from the shared package.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears pipeline valid bits and output registers.
- en  in  1  operation request; A_in/B_in/zeta sampled on every rising edge where en=1.
- A_in  in  23  first coefficient, canonical [0, q−1].
- B_in  in  23  second coefficient, canonical [0, q−1].
- zeta  in  23  twiddle factor, canonical [0, q−1].
- A_out  out  23  (A + zeta·B) mod q, canonical.
- B_out  out  23  (A − zeta·B) mod q, canonical.
- valid  out  1  high for exactly one cycle per accepted operation, aligned with its results.

## Operation
- No handshake back-pressure. Every edge with en=1 and reset=0 starts an operation. Throughput is one per cycle.
- Multiply: full 46-bit product P = zeta·B_in.
- Reduction is exact, with no Montgomery factor. Fold using 2^23 ≡ 2^13 − 1 (mod q):
  - P ≡ P[22:0] + (P[45:23] << 13) − P[45:23].
  - Apply the fold twice.
  - Finish with conditional subtractions of q to reach [0, q−1].
- Add: s = A + t; if s ≥ q then s − q.
- Sub: d = A − t; if negative then d + q.
- A is delayed alongside the product so it stays paired with its t.
- Inputs must be canonical. For non-canonical inputs the data outputs are unspecified, but valid timing is unchanged.
- A_out/B_out load only when a result is valid and hold their last value otherwise.

## Timing
- Latency is 4 cycles. Inputs sampled at edge k; A_out, B_out and valid are updated at edge k+4.
- Suggested stage split:
  - edge k: product and A registered.
  - edge k+1: fold 1.
  - edge k+2: fold 2 plus final correction, giving t.
  - edge k+3: add/sub, outputs registered at k+4.
- en high for N consecutive cycles gives valid high for N consecutive cycles, 4 cycles later, with results in issue order.
- Gaps in en produce matching gaps in valid.
- Reset values: A_out=0, B_out=0, valid=0, all pipeline valid bits 0.
- Reset asserted mid-operation: all in-flight operations are discarded. valid is 0 from the edge after reset and stays 0 while reset=1.
- Reset=1 together with en=1: the request is ignored.
- First accepted operation is on the first edge with reset=0 and en=1.

## Structure
- Package ml_dsa_pkg:
  - DATA_W = 23.
  - Q = 23'd8380417.
  - 23-bit coefficient typedef.
- Sub-module mod_mul: zeta·B with the two-stage fold reduction, 3-cycle latency, canonical output.
- bt_unit instantiates mod_mul and contains:
  - the A delay line;
  - the valid shift register (4 deep);
  - the add/sub-mod-q stage.

## Test plan
- Reset low, then A=1, B=3, zeta=3383, en=1 for one cycle -> 4 cycles later valid=1 for one cycle, A_out=10150, B_out=8370269.
- A=0, B=1, zeta=8380416 -> A_out=8380416, B_out=1. Then A=5, same B/zeta -> A_out=4, B_out=6.
- A=8380416, B=8380416, zeta=8380416 (t=1) -> A_out=0, B_out=8380415, checking wrap on add.
- 64 back-to-back random canonical triples -> 64 consecutive valid cycles. Results match the golden model ((A ± zeta·B) mod q) in order, with exactly one valid per request.
- Issue 3 operations, assert reset for one cycle while they are in flight -> no valid pulses from them. Outputs are 0 after reset, and the next operation completes normally.
- After a result, hold en=0 for 10 cycles -> valid stays 0 and A_out/B_out hold the last result.
